// File: rtl/uart_pkg.sv
// Shared definitions for the UART transceiver.
// Holds the parity mode encodings, the TX and RX state enums and the
// parity helper used by both the transmit path and the receive checker.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Widest legal payload; the parity helper takes vectors zero-extended to this.
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Parity bit for a payload; zero padding does not change the XOR.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] vec, input int mode);
    logic p;
    p = ^vec;
    case (mode)
      PAR_ODD:  return ~p;
      PAR_EVEN: return p;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop synchroniser, mid-bit sampling FSM with start-glitch
// rejection, and parity / framing error reporting.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   line              - serial input (asynchronous)
//   data_out          - last received payload
//   done              - one-cycle pulse when data_out / error flags update
//   parity_err        - parity mismatch on last frame (0 when parity disabled)
//   frame_err         - first stop bit sampled low on last frame
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 40,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 line,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 done,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT * 2);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [BAUD_W-1:0] BIT_END  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_END = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

  rx_state_t            state_r;
  logic                 sync1_r;
  logic                 sync2_r;
  logic [BAUD_W-1:0]    baud_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_bit_r;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= line;
      sync2_r <= sync1_r;
    end
  end

  // Receive FSM: half-bit wait after the falling edge, then one sample per bit centre.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= RX_IDLE;
      baud_cnt_r <= {BAUD_W{1'b0}};
      bit_cnt_r  <= {BIT_W{1'b0}};
      shift_r    <= {DATA_BITS{1'b0}};
      par_bit_r  <= 1'b0;
      data_out   <= {DATA_BITS{1'b0}};
      done       <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        RX_IDLE: begin
          baud_cnt_r <= {BAUD_W{1'b0}};
          bit_cnt_r  <= {BIT_W{1'b0}};
          if (!sync2_r) begin
            state_r <= RX_START;
          end else begin
            state_r <= RX_IDLE;
          end
        end
        RX_START: begin
          if (baud_cnt_r == HALF_END) begin
            baud_cnt_r <= {BAUD_W{1'b0}};
            // Line back high at the start-bit centre means a glitch.
            state_r    <= sync2_r ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
          end
        end
        RX_DATA: begin
          if (baud_cnt_r == BIT_END) begin
            baud_cnt_r <= {BAUD_W{1'b0}};
            shift_r    <= {sync2_r, shift_r[DATA_BITS-1:1]};
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r <= {BIT_W{1'b0}};
              state_r   <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + BIT_W'(1);
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
          end
        end
        RX_PARITY: begin
          if (baud_cnt_r == BIT_END) begin
            baud_cnt_r <= {BAUD_W{1'b0}};
            par_bit_r  <= sync2_r;
            state_r    <= RX_STOP;
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
          end
        end
        RX_STOP: begin
          if (baud_cnt_r == BIT_END) begin
            // Deliver the frame even when the stop bit is bad; flags tell the host.
            baud_cnt_r <= {BAUD_W{1'b0}};
            data_out   <= shift_r;
            done       <= 1'b1;
            parity_err <= (PARITY != PAR_NONE) &&
                          (par_bit_r != calc_parity(MAX_DATA_BITS'(shift_r), PARITY));
            frame_err  <= ~sync2_r;
            state_r    <= RX_IDLE;
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
          end
        end
        default: begin
          state_r    <= RX_IDLE;
          baud_cnt_r <= {BAUD_W{1'b0}};
          bit_cnt_r  <= {BIT_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// Single-clock parametrised UART: inline TX FSM plus one uart_rx_core.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   send         - transmit request, rising edge starts a frame when idle
//   data_in      - payload captured on the accepted send edge
//   loopback     - 1 routes tx into the receiver instead of the rx pin
//   rx           - serial input pin
//   tx           - serial output pin, idle high
//   busy         - TX frame in progress
//   data_out, done, parity_err, frame_err - receiver results
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 40,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 loopback,
  input  logic                 rx,
  output logic                 tx,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 done,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT * 2);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [BAUD_W-1:0] BIT_END  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_END = BAUD_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);

  tx_state_t            tx_state_r;
  logic                 send_q_r;
  logic [BAUD_W-1:0]    baud_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [DATA_BITS-1:0] tx_shift_r;
  logic                 tx_par_r;
  logic                 rx_src_s;

  assign rx_src_s = loopback ? tx : rx;

  // Transmit FSM; accept uses the registered state so a send edge coinciding
  // with the end of STOP is dropped rather than queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_r <= TX_IDLE;
      send_q_r   <= 1'b0;
      baud_cnt_r <= {BAUD_W{1'b0}};
      bit_cnt_r  <= {BIT_W{1'b0}};
      tx_shift_r <= {DATA_BITS{1'b0}};
      tx_par_r   <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
    end else begin
      send_q_r <= send;
      case (tx_state_r)
        TX_IDLE: begin
          baud_cnt_r <= {BAUD_W{1'b0}};
          bit_cnt_r  <= {BIT_W{1'b0}};
          if (send && !send_q_r) begin
            tx_state_r <= TX_START;
            tx_shift_r <= data_in;
            tx_par_r   <= calc_parity(MAX_DATA_BITS'(data_in), PARITY);
            tx         <= 1'b0;
            busy       <= 1'b1;
          end else begin
            tx   <= 1'b1;
            busy <= 1'b0;
          end
        end
        TX_START: begin
          if (baud_cnt_r == BIT_END) begin
            baud_cnt_r <= {BAUD_W{1'b0}};
            tx_state_r <= TX_DATA;
            tx         <= tx_shift_r[0];
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
          end
        end
        TX_DATA: begin
          if (baud_cnt_r == BIT_END) begin
            baud_cnt_r <= {BAUD_W{1'b0}};
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r <= {BIT_W{1'b0}};
              if (PARITY != PAR_NONE) begin
                tx_state_r <= TX_PARITY;
                tx         <= tx_par_r;
              end else begin
                tx_state_r <= TX_STOP;
                tx         <= 1'b1;
              end
            end else begin
              bit_cnt_r  <= bit_cnt_r + BIT_W'(1);
              tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
              tx         <= tx_shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
          end
        end
        TX_PARITY: begin
          if (baud_cnt_r == BIT_END) begin
            baud_cnt_r <= {BAUD_W{1'b0}};
            tx_state_r <= TX_STOP;
            tx         <= 1'b1;
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
          end
        end
        TX_STOP: begin
          // All stop bits are one long run of high; counter is sized for two.
          if (baud_cnt_r == STOP_END) begin
            baud_cnt_r <= {BAUD_W{1'b0}};
            tx_state_r <= TX_IDLE;
            busy       <= 1'b0;
          end else begin
            baud_cnt_r <= baud_cnt_r + BAUD_W'(1);
          end
        end
        default: begin
          tx_state_r <= TX_IDLE;
          tx         <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_BITS    (DATA_BITS),
    .PARITY       (PARITY)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .line       (rx_src_s),
    .data_out   (data_out),
    .done       (done),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
Parametrised, single-clock UART that merges TX and RX into one block.
- Successor to the fixed 8N1 dual-clock UART_Protocol.
- Adds configurable data width, parity, stop-bit count, mid-bit RX sampling with start-glitch rejection, parity/framing error flags and a runtime loopback path.
- Sits between the byte-level host logic and the serial pins.

Parameters:
CLKS_PER_BIT, 40, clk cycles per baud bit (384 kHz clk -> 9600 baud); must be >= 4
DATA_BITS, 8, payload width, legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, TX stop bits, legal 1 or 2; RX checks only the first

Ports:
clk  in  1  single clock for TX and RX
reset  in  1  synchronous, active-high
send  in  1  transmit request; rising edge starts a frame
data_in  in  DATA_BITS  payload, captured on accepted send edge
loopback  in  1  1 = RX input internally driven from tx, rx pin ignored
rx  in  1  serial input, asynchronous
tx  out  1  serial output, idle high
busy  out  1  TX frame in progress
data_out  out  DATA_BITS  last received payload
done  out  1  one-cycle pulse, new data_out valid
parity_err  out  1  parity mismatch on last frame (0 when PARITY = 0)
frame_err  out  1  first stop bit sampled low on last frame

Behaviour:
Reset (synchronous, any cycle, including mid-frame):
- Both FSMs go to IDLE; any frame in progress is aborted and not resumed.
- Outputs: tx = 1, busy = 0, done = 0, data_out = 0, parity_err = 0, frame_err = 0.
- send edge register = 0; RX synchroniser flops = 1.

TX FSM (IDLE -> START -> DATA -> PARITY -> STOP -> IDLE):
- Accept: send = 1 and send_q = 0 while in IDLE. A level held high is never re-accepted.
- Cycle after accept: data_in latched, busy = 1, tx = 0 (START), bit counter cleared.
- Each state holds for CLKS_PER_BIT cycles per bit.
- DATA shifts LSB first for DATA_BITS bits.
- PARITY is skipped when PARITY = 0. Odd: XOR of payload, inverted. Even: XOR of payload.
- STOP drives tx = 1 for STOP_BITS * CLKS_PER_BIT cycles.
- busy falls on the cycle the FSM re-enters IDLE.
- A send edge while busy, including during STOP, is ignored and not queued.
- A send edge on the same cycle busy falls is ignored, because the accept check uses the registered state.

RX FSM (IDLE -> START -> DATA -> PARITY -> STOP -> IDLE):
- RX source is a 2-flop synchroniser on (loopback ? tx : rx).
- IDLE: leaves on synchronised low.
- START: counts CLKS_PER_BIT/2 (integer division). If the line is still low, go to DATA; otherwise it is a glitch, return to IDLE with no done.
- DATA/PARITY/STOP: sample once every CLKS_PER_BIT cycles at bit centre. DATA shifts LSB first.
- Parity check: the parity sample is compared against parity computed over the received payload.
- At the first stop-bit centre sample, in one cycle: data_out updated, done = 1, parity_err / frame_err updated.
  - frame_err = 1 if that stop sample is 0.
  - The frame is still delivered.
- Error flags hold until the next done. FSM returns to IDLE immediately after the stop sample.
- TX and RX are independent; full-duplex operation is legal.

Latency:
- done asserts (1 + DATA_BITS + P + 0.5) * CLKS_PER_BIT + 3 ±1 cycles after the tx start edge, where P = 1 if PARITY != 0 else 0.
- 8N1 at CLKS_PER_BIT = 40: 383 ±1 cycles.

Arithmetic:
- Baud counter width is clog2(CLKS_PER_BIT * 2).
- Bit counter width is clog2(DATA_BITS + 1). It wraps only via state exit, never free-running.

Decomposition:
- Package uart_pkg holds:
  - parity encodings PAR_NONE / PAR_ODD / PAR_EVEN;
  - TX and RX state enums;
  - a parity function taking a vector and a mode.
- One sub-module is natural: uart_rx_core (synchroniser, RX FSM, error logic), instantiated once.
- The TX FSM stays inline in uart_transceiver.

Test Plan:
1. 8N1 with loopback = 1: send edge with data_in = 8'h18 -> tx shows 0,0,0,0,1,1,0,0,0,1 at 40-cycle bit intervals; done ~383 cycles later with data_out = 8'h18, no errors; busy low 400 cycles after accept.
2. Busy rejection: send 8'h51, then send edges with 8'h96 at +44 cycles and 8'h48 at +88 cycles, plus one edge during STOP -> only 8'h51 is received; exactly one done.
3. Level hold: send held high for 1000 cycles with 8'hA5 -> exactly one frame transmitted.
4. Reset mid-frame: reset for 2 cycles during DATA bit 3 of 8'h88 -> tx = 1 and busy = 0 on the cycle after reset; no done; next send of 8'h07 is received correctly.
5. PARITY = 2 (even), loopback = 0: bench drives 8'h55 with parity bit 1 on rx -> done, parity_err = 1. Then a correct frame with 8'hFF -> parity_err = 0. Then a frame with stop bit 0 -> frame_err = 1.
6. Glitch and width: 10-cycle low pulse on rx -> no done. Then DATA_BITS = 9, STOP_BITS = 2 loopback of 9'h1F0 -> data_out = 9'h1F0; tx frame length is 12 * CLKS_PER_BIT.
